// File: rtl/ahb_master_data_buf.sv
// ahb_master_data_buf
//   Byte-addressable data buffer for the AHB-Lite master. Bus read data is
//   stored into it and bus write data is loaded out of it. Accesses are sized
//   (byte, half, word, and dword when DATA_W=64) and little-endian. A command
//   is accepted on a valid/ready handshake. Misaligned or oversized commands
//   are rejected: each rejection pulses ERR and bumps a saturating counter.
//
// Optional feature (macro AHB_MASTER_DATA_BUF_SIGN_EXT_EN):
//   Adds CMD_SIGNED. When it is set, narrow loads sign-extend instead of
//   zero-extend.
//
// Parameters:
//   DATA_W  data path width, 32 or 64
//   DEPTH   storage size in bytes, power of two, >= DATA_W/8
//   ADDR_W  byte address width, derived from DEPTH (leave at default)
//
// Ports:
//   HCLK            clock, rising edge
//   HRESET          asynchronous active-high reset
//   HREADY          bus ready, registered before use
//   INTERRUPT_FLAG  master interrupt, registered before use
//   CMD_VALID       command request
//   CMD_READY       command can be accepted this cycle
//   CMD_STORE       1 = write WDATA into buffer, 0 = load from buffer
//   CMD_SIZE        0 byte, 1 half, 2 word, 3 dword, 4..7 illegal
//   CMD_ADDR        byte address of the least-significant byte
//   CMD_SIGNED      sign-extend narrow loads (optional feature only)
//   WDATA           store data, low bytes used per size
//   RDATA           load data, zero- or sign-extended
//   RVALID          one-cycle pulse, RDATA updated
//   ERR             one-cycle pulse, command rejected
//   ERR_CNT         saturating count of ERR pulses
module ahb_master_data_buf #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              HREADY,
  input  logic              INTERRUPT_FLAG,
  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic              CMD_STORE,
  input  logic [2:0]        CMD_SIZE,
  input  logic [ADDR_W-1:0] CMD_ADDR,
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
  input  logic              CMD_SIGNED,
`endif
  input  logic [DATA_W-1:0] WDATA,
  output logic [DATA_W-1:0] RDATA,
  output logic              RVALID,
  output logic              ERR,
  output logic [7:0]        ERR_CNT
);

  localparam int NBYTES   = DATA_W / 8;
  localparam int MAX_SIZE = $clog2(NBYTES);

  logic [7:0] mem [DEPTH];

  logic hready_q;
  logic int_q;

  logic                accept;
  logic                legal;
  logic [ADDR_W-1:0]   align_mask;
  logic [NBYTES-1:0]   byte_en;
  logic [DATA_W-1:0]   load_data;

  // Bus qualifiers. The ready path sees them one cycle late. A fall of HREADY
  // therefore does not disturb a command accepted in the same cycle.
  // NOTE: sequential state uses non-blocking (<=) so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      hready_q <= 1'b1;
      int_q    <= 1'b0;
    end else begin
      hready_q <= HREADY;
      int_q    <= INTERRUPT_FLAG;
    end
  end

  assign CMD_READY = hready_q & ~int_q;
  assign accept    = CMD_VALID & CMD_READY;

  // Legality and per-byte lane enables. The byte count is 2^CMD_SIZE. An
  // address is aligned when its low CMD_SIZE bits are zero. Legal aligned
  // accesses never run past DEPTH, so CMD_ADDR+k needs no wrap handling.
  // NOTE: every signal assigned in always_comb receives a default first, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    align_mask = '0;
    byte_en    = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (i < int'(CMD_SIZE)) align_mask[i] = 1'b1;
    end
    for (int k = 0; k < NBYTES; k++) begin
      if (k < (1 << CMD_SIZE)) byte_en[k] = 1'b1;
    end
    legal = (int'(CMD_SIZE) <= MAX_SIZE) && ((CMD_ADDR & align_mask) == '0);
  end

  // Load data is assembled from the lanes covered by the access. Upper lanes
  // are zero, or copies of the top loaded byte's MSB for a signed load.
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
  logic sign_bit;
`endif

  always_comb begin
    load_data = '0;
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
    sign_bit  = 1'b0;
`endif
    for (int k = 0; k < NBYTES; k++) begin
      if (byte_en[k]) begin
        load_data[8*k +: 8] = mem[CMD_ADDR + ADDR_W'(k)];
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
        sign_bit = mem[CMD_ADDR + ADDR_W'(k)][7];
`endif
      end
    end
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
    if (CMD_SIGNED && (int'(CMD_SIZE) < MAX_SIZE)) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (!byte_en[k]) load_data[8*k +: 8] = {8{sign_bit}};
      end
    end
`endif
  end

  // Storage. A load issued right after a store to the same bytes returns the
  // new data, because the store commits on its own accepting edge.
  // NOTE: the memory is cleared on reset because reset must leave every byte
  // zero. This rules out a RAM macro and keeps the array in flops.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (accept && legal && CMD_STORE) begin
      for (int k = 0; k < NBYTES; k++) begin
        if (byte_en[k]) mem[CMD_ADDR + ADDR_W'(k)] <= WDATA[8*k +: 8];
      end
    end
  end

  // Response registers. RDATA changes only on an accepted load. An illegal
  // load still returns a response (RVALID with RDATA=0), so the requester
  // never waits for data that will not come.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      RDATA   <= '0;
      RVALID  <= 1'b0;
      ERR     <= 1'b0;
      ERR_CNT <= '0;
    end else begin
      RVALID <= accept & ~CMD_STORE;
      ERR    <= accept & ~legal;
      if (accept && !CMD_STORE) RDATA <= legal ? load_data : '0;
      if (accept && !legal && (ERR_CNT != 8'hFF)) ERR_CNT <= ERR_CNT + 8'd1;
    end
  end

endmodule

// File: tb/tb_ahb_master_data_buf.sv
module tb_ahb_master_data_buf;

  logic        HCLK;
  logic        HRESET;
  logic        HREADY;
  logic        INTERRUPT_FLAG;
  logic        CMD_VALID;
  logic        CMD_READY;
  logic        CMD_STORE;
  logic [2:0]  CMD_SIZE;
  logic [7:0]  CMD_ADDR;
  logic        CMD_SIGNED;
  logic [31:0] WDATA;
  logic [31:0] RDATA;
  logic        RVALID;
  logic        ERR;
  logic [7:0]  ERR_CNT;

  int n_cmp = 0;
  int n_bad = 0;

  ahb_master_data_buf #(.DATA_W(32), .DEPTH(256)) dut (
    .HCLK           (HCLK),
    .HRESET         (HRESET),
    .HREADY         (HREADY),
    .INTERRUPT_FLAG (INTERRUPT_FLAG),
    .CMD_VALID      (CMD_VALID),
    .CMD_READY      (CMD_READY),
    .CMD_STORE      (CMD_STORE),
    .CMD_SIZE       (CMD_SIZE),
    .CMD_ADDR       (CMD_ADDR),
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
    .CMD_SIGNED     (CMD_SIGNED),
`endif
    .WDATA          (WDATA),
    .RDATA          (RDATA),
    .RVALID         (RVALID),
    .ERR            (ERR),
    .ERR_CNT        (ERR_CNT)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Inputs change on the falling edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge HCLK);
    @(negedge HCLK);
  endtask

  task automatic drive(input logic st, input logic [2:0] sz, input logic [7:0] a,
                       input logic [31:0] wd);
    CMD_VALID = 1'b1;
    CMD_STORE = st;
    CMD_SIZE  = sz;
    CMD_ADDR  = a;
    WDATA     = wd;
  endtask

  task automatic idle();
    CMD_VALID = 1'b0;
    CMD_STORE = 1'b0;
    CMD_SIZE  = 3'd0;
    CMD_ADDR  = 8'h00;
    WDATA     = 32'h0;
  endtask

  task automatic cmp32(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic test_reset();
    HRESET = 1'b1; HREADY = 1'b1; INTERRUPT_FLAG = 1'b0; CMD_SIGNED = 1'b0;
    idle();
    repeat (3) @(negedge HCLK);
    HRESET = 1'b0;
    cmp32("reset_rdata", RDATA, 32'h0);
    cmp32("reset_rvalid", {31'b0, RVALID}, 32'h0);
    cmp32("reset_err", {31'b0, ERR}, 32'h0);
    cmp32("reset_err_cnt", {24'b0, ERR_CNT}, 32'h0);
    cmp32("reset_cmd_ready", {31'b0, CMD_READY}, 32'h1);
    drive(1'b0, 3'd2, 8'h00, 32'h0);
    tick();
    idle();
    cmp32("first_load_rvalid", {31'b0, RVALID}, 32'h1);
    cmp32("first_load_rdata", RDATA, 32'h0);
    cmp32("first_load_err", {31'b0, ERR}, 32'h0);
    tick();
    cmp32("first_load_rvalid_drop", {31'b0, RVALID}, 32'h0);
  endtask

  task automatic test_store_load();
    drive(1'b1, 3'd2, 8'h10, 32'hA1B2C3D4);
    tick();
    cmp32("store_no_rvalid", {31'b0, RVALID}, 32'h0);
    drive(1'b0, 3'd0, 8'h11, 32'h0);
    tick();
    drive(1'b0, 3'd1, 8'h12, 32'h0);
    cmp32("byte_load_rvalid", {31'b0, RVALID}, 32'h1);
    cmp32("byte_load_rdata", RDATA, 32'h000000C3);
    tick();
    idle();
    cmp32("half_load_rvalid", {31'b0, RVALID}, 32'h1);
    cmp32("half_load_rdata", RDATA, 32'h0000A1B2);
    tick();
    cmp32("hold_rvalid", {31'b0, RVALID}, 32'h0);
    cmp32("hold_rdata", RDATA, 32'h0000A1B2);
    // Store immediately followed by a load of the same bytes.
    drive(1'b1, 3'd1, 8'h14, 32'h00001234);
    tick();
    drive(1'b0, 3'd2, 8'h14, 32'h0);
    tick();
    idle();
    cmp32("store_then_load", RDATA, 32'h00001234);
  endtask

  task automatic test_misaligned();
    drive(1'b1, 3'd1, 8'h21, 32'h0000BEEF);
    tick();
    idle();
    cmp32("misaligned_err", {31'b0, ERR}, 32'h1);
    cmp32("misaligned_rvalid", {31'b0, RVALID}, 32'h0);
    cmp32("misaligned_err_cnt", {24'b0, ERR_CNT}, 32'h1);
    tick();
    cmp32("err_pulse_drop", {31'b0, ERR}, 32'h0);
    drive(1'b0, 3'd2, 8'h20, 32'h0);
    tick();
    idle();
    cmp32("misaligned_mem_kept", RDATA, 32'h0);
    cmp32("legal_load_no_err", {31'b0, ERR}, 32'h0);
  endtask

  task automatic test_illegal_size();
    drive(1'b0, 3'd2, 8'h10, 32'h0);
    tick();
    drive(1'b0, 3'd3, 8'h08, 32'h0);
    cmp32("pre_illegal_rdata", RDATA, 32'hA1B2C3D4);
    tick();
    drive(1'b1, 3'd5, 8'h00, 32'hFFFFFFFF);
    cmp32("size3_rvalid", {31'b0, RVALID}, 32'h1);
    cmp32("size3_rdata", RDATA, 32'h0);
    cmp32("size3_err", {31'b0, ERR}, 32'h1);
    tick();
    idle();
    cmp32("size5_store_err", {31'b0, ERR}, 32'h1);
    cmp32("size5_store_rvalid", {31'b0, RVALID}, 32'h0);
    cmp32("err_cnt_3", {24'b0, ERR_CNT}, 32'd3);
    tick();
  endtask

  task automatic test_saturation();
    drive(1'b1, 3'd2, 8'h11, 32'hFFFFFFFF);
    repeat (300) tick();
    idle();
    tick();
    cmp32("err_cnt_saturated", {24'b0, ERR_CNT}, 32'd255);
    cmp32("err_idle", {31'b0, ERR}, 32'h0);
    drive(1'b0, 3'd2, 8'h10, 32'h0);
    tick();
    idle();
    cmp32("illegal_stores_no_write", RDATA, 32'hA1B2C3D4);
  endtask

  task automatic test_hready_stall();
    HREADY = 1'b0;
    drive(1'b1, 3'd0, 8'h31, 32'h00000066);
    tick();
    cmp32("hready_drop_t1", {31'b0, CMD_READY}, 32'h0);
    drive(1'b1, 3'd0, 8'h30, 32'h00000055);
    tick();
    cmp32("hready_drop_t2", {31'b0, CMD_READY}, 32'h0);
    tick();
    cmp32("hready_drop_t3", {31'b0, CMD_READY}, 32'h0);
    HREADY = 1'b1;
    tick();
    cmp32("hready_back", {31'b0, CMD_READY}, 32'h1);
    tick();
    idle();
    drive(1'b0, 3'd1, 8'h30, 32'h0);
    tick();
    idle();
    cmp32("stall_store_result", RDATA, 32'h00006655);
  endtask

  task automatic test_interrupt();
    INTERRUPT_FLAG = 1'b1;
    tick();
    cmp32("int_blocks_ready", {31'b0, CMD_READY}, 32'h0);
    INTERRUPT_FLAG = 1'b0;
    drive(1'b0, 3'd0, 8'h30, 32'h0);
    tick();
    cmp32("int_no_accept", {31'b0, RVALID}, 32'h0);
    cmp32("int_ready_back", {31'b0, CMD_READY}, 32'h1);
    tick();
    idle();
    cmp32("int_load_rvalid", {31'b0, RVALID}, 32'h1);
    cmp32("int_load_rdata", RDATA, 32'h00000055);
    tick();
  endtask

`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
  task automatic test_sign_ext();
    drive(1'b1, 3'd0, 8'h40, 32'h00000080);
    tick();
    CMD_SIGNED = 1'b1;
    drive(1'b0, 3'd0, 8'h40, 32'h0);
    tick();
    CMD_SIGNED = 1'b0;
    cmp32("signed_byte_load", RDATA, 32'hFFFFFF80);
    tick();
    idle();
    cmp32("unsigned_byte_load", RDATA, 32'h00000080);
    CMD_SIGNED = 1'b1;
    drive(1'b0, 3'd2, 8'h10, 32'h0);
    tick();
    idle();
    CMD_SIGNED = 1'b0;
    cmp32("signed_full_width", RDATA, 32'hA1B2C3D4);
  endtask
`endif

  task automatic test_reset_mid();
    drive(1'b0, 3'd2, 8'h10, 32'h0);
    @(posedge HCLK);
    #2;
    HRESET = 1'b1;
    #1;
    cmp32("async_reset_rvalid", {31'b0, RVALID}, 32'h0);
    cmp32("async_reset_err_cnt", {24'b0, ERR_CNT}, 32'h0);
    cmp32("async_reset_rdata", RDATA, 32'h0);
    @(negedge HCLK);
    idle();
    tick();
    HRESET = 1'b0;
    cmp32("post_reset_ready", {31'b0, CMD_READY}, 32'h1);
    drive(1'b0, 3'd2, 8'h10, 32'h0);
    tick();
    idle();
    cmp32("post_reset_mem_clear", RDATA, 32'h0);
    cmp32("post_reset_rvalid", {31'b0, RVALID}, 32'h1);
    tick();
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_illegal_size();
    test_saturation();
    test_hready_stall();
    test_interrupt();
`ifdef AHB_MASTER_DATA_BUF_SIGN_EXT_EN
    test_sign_ext();
`endif
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
